// File: rtl/ieu_pkg.sv
// Shared definitions for the IEU issue controller: FSM state encoding,
// operand-forwarding select codes and register-index width.
package ieu_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } issue_state_e;

  // Operand source select codes
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_RES = 2'b01;  // IEU result register
  localparam logic [1:0] FWD_LD  = 2'b10;  // load data

  // True when a read of rs is enabled and hits a real (non-x0) destination rd
  function automatic logic reg_match(input logic                 use_rs,
                                     input logic [REG_IDX_W-1:0] rs,
                                     input logic [REG_IDX_W-1:0] rd);
    return use_rs && (rd != {REG_IDX_W{1'b0}}) && (rs == rd);
  endfunction

endpackage

// File: rtl/ieu_issue_ctrl_if.sv
// Decode -> issue -> IEU handshake bundle. The master side is the decode
// stage / IEU environment, the slave side is the issue controller.
interface ieu_issue_ctrl_if;
  import ieu_pkg::*;

  logic                 dec_valid;
  logic                 dec_ready;
  logic [REG_IDX_W-1:0] dec_rd;
  logic [REG_IDX_W-1:0] dec_rs1;
  logic [REG_IDX_W-1:0] dec_rs2;
  logic                 dec_use_rs1;
  logic                 dec_use_rs2;
  logic                 dec_is_load;
  logic                 dec_is_cf;
  logic                 ex_ready;
  logic                 je;
  logic                 issue_valid;
  logic [1:0]           fwd_sel1;
  logic [1:0]           fwd_sel2;
  logic                 flush;

  modport master (
    output dec_valid, dec_rd, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_is_load, dec_is_cf, ex_ready, je,
    input  dec_ready, issue_valid, fwd_sel1, fwd_sel2, flush
  );

  modport slave (
    input  dec_valid, dec_rd, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_is_load, dec_is_cf, ex_ready, je,
    output dec_ready, issue_valid, fwd_sel1, fwd_sel2, flush
  );

endinterface

// File: rtl/ieu_hazard_cmp.sv
// Per-operand compare against the W slot (op issued last cycle) and against
// the load that caused the most recent load-use stall. Produces the load-use
// hazard flag and the operand forwarding select.
module ieu_hazard_cmp
  import ieu_pkg::*;
(
  input  logic                 use_rs,
  input  logic [REG_IDX_W-1:0] rs,
  input  logic                 w_valid,
  input  logic [REG_IDX_W-1:0] w_rd,
  input  logic                 w_is_load,
  input  logic                 ld_pend,
  input  logic [REG_IDX_W-1:0] ld_rd,
  output logic                 hazard,
  output logic [1:0]           fwd_sel
);

  logic w_hit_s;
  logic ld_hit_s;

  // Compare operand against W slot and stalled-load destination
  always_comb begin
    w_hit_s  = w_valid && reg_match(use_rs, rs, w_rd);
    ld_hit_s = ld_pend && reg_match(use_rs, rs, ld_rd);
    hazard   = w_hit_s && w_is_load;
    if (ld_hit_s) begin
      fwd_sel = FWD_LD;
    end else if (w_hit_s && !w_is_load) begin
      fwd_sel = FWD_RES;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/ieu_issue_ctrl.sv
// IEU issue controller: accepts decoded ops, resolves load-use stalls and
// result forwarding against the op issued last cycle, and discards
// FLUSH_CYCLES front-end ops after a taken jump/branch.
// Optional feature: define IEU_ISSUE_CTRL_PERF_EN to add XLEN-wide
// issued / load-stall / flush performance counters.
module ieu_issue_ctrl
  import ieu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic             clk,
  input  logic             reset,
  ieu_issue_ctrl_if.slave  bus
`ifdef IEU_ISSUE_CTRL_PERF_EN
  ,
  output logic [XLEN-1:0]  perf_issued,
  output logic [XLEN-1:0]  perf_stalls,
  output logic [XLEN-1:0]  perf_flushes
`endif
);

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 7) || (XLEN < 1)) begin : g_param_check
    $error("ieu_issue_ctrl: FLUSH_CYCLES must be 1..7 and XLEN >= 1");
  end

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  issue_state_e         state_r;
  issue_state_e         state_nxt_s;
  logic                 w_valid_r;
  logic [REG_IDX_W-1:0] w_rd_r;
  logic                 w_is_load_r;
  logic                 ld_pend_r;
  logic [REG_IDX_W-1:0] ld_rd_r;
  logic [2:0]           flush_cnt_r;
  logic                 flush_r;
  logic                 dec_ready_s;
  logic                 issue_valid_s;
  logic                 take_jump_s;
  logic                 enter_stall_s;
  logic                 hazard1_s;
  logic                 hazard2_s;
  logic                 hazard_s;
  logic [1:0]           fwd_sel1_s;
  logic [1:0]           fwd_sel2_s;

  ieu_hazard_cmp u_cmp_rs1 (
    .use_rs   (bus.dec_use_rs1),
    .rs       (bus.dec_rs1),
    .w_valid  (w_valid_r),
    .w_rd     (w_rd_r),
    .w_is_load(w_is_load_r),
    .ld_pend  (ld_pend_r),
    .ld_rd    (ld_rd_r),
    .hazard   (hazard1_s),
    .fwd_sel  (fwd_sel1_s)
  );

  ieu_hazard_cmp u_cmp_rs2 (
    .use_rs   (bus.dec_use_rs2),
    .rs       (bus.dec_rs2),
    .w_valid  (w_valid_r),
    .w_rd     (w_rd_r),
    .w_is_load(w_is_load_r),
    .ld_pend  (ld_pend_r),
    .ld_rd    (ld_rd_r),
    .hazard   (hazard2_s),
    .fwd_sel  (fwd_sel2_s)
  );

  assign hazard_s = hazard1_s | hazard2_s;

  // Next-state and handshake decode; ex_ready low freezes RUN/LOAD_STALL
  always_comb begin
    state_nxt_s   = state_r;
    dec_ready_s   = 1'b0;
    issue_valid_s = 1'b0;
    take_jump_s   = 1'b0;
    enter_stall_s = 1'b0;
    case (state_r)
      RUN: begin
        dec_ready_s   = bus.ex_ready & ~hazard_s;
        issue_valid_s = bus.dec_valid & dec_ready_s;
        take_jump_s   = issue_valid_s & bus.dec_is_cf & bus.je;
        enter_stall_s = bus.dec_valid & bus.ex_ready & hazard_s;
        if (take_jump_s) begin
          state_nxt_s = FLUSH;
        end else if (enter_stall_s) begin
          state_nxt_s = LOAD_STALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LOAD_STALL: begin
        if (bus.ex_ready) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = LOAD_STALL;
        end
      end
      FLUSH: begin
        // Wrong-path ops are swallowed regardless of downstream readiness
        dec_ready_s = 1'b1;
        if (bus.dec_valid && (flush_cnt_r <= 3'd1)) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // FSM state, flush pulse and wrong-path op counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RUN;
      flush_r     <= 1'b0;
      flush_cnt_r <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      flush_r <= take_jump_s;
      if (take_jump_s) begin
        flush_cnt_r <= FLUSH_INIT;
      end else if ((state_r == FLUSH) && bus.dec_valid && (flush_cnt_r != 3'd0)) begin
        flush_cnt_r <= flush_cnt_r - 3'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  // W slot tracks last cycle's issued op; held while the IEU is back-pressuring
  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid_r   <= 1'b0;
      w_rd_r      <= {REG_IDX_W{1'b0}};
      w_is_load_r <= 1'b0;
    end else if (bus.ex_ready || (state_r == FLUSH)) begin
      w_valid_r   <= issue_valid_s;
      w_rd_r      <= bus.dec_rd;
      w_is_load_r <= bus.dec_is_load;
    end else begin
      w_valid_r   <= w_valid_r;
      w_rd_r      <= w_rd_r;
      w_is_load_r <= w_is_load_r;
    end
  end

  // Remember the stalling load's rd so the stalled op can take load data
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_pend_r <= 1'b0;
      ld_rd_r   <= {REG_IDX_W{1'b0}};
    end else if (enter_stall_s) begin
      ld_pend_r <= 1'b1;
      ld_rd_r   <= w_rd_r;
    end else if (issue_valid_s) begin
      ld_pend_r <= 1'b0;
      ld_rd_r   <= ld_rd_r;
    end else begin
      ld_pend_r <= ld_pend_r;
      ld_rd_r   <= ld_rd_r;
    end
  end

`ifdef IEU_ISSUE_CTRL_PERF_EN
  // Free-running wrap-around performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued  <= {XLEN{1'b0}};
      perf_stalls  <= {XLEN{1'b0}};
      perf_flushes <= {XLEN{1'b0}};
    end else begin
      perf_issued  <= perf_issued  + XLEN'(issue_valid_s);
      perf_stalls  <= perf_stalls  + XLEN'((state_r == LOAD_STALL) && bus.ex_ready);
      perf_flushes <= perf_flushes + XLEN'(flush_r);
    end
  end
`endif

  assign bus.dec_ready   = dec_ready_s;
  assign bus.issue_valid = issue_valid_s;
  assign bus.fwd_sel1    = fwd_sel1_s;
  assign bus.fwd_sel2    = fwd_sel2_s;
  assign bus.flush       = flush_r;

endmodule

// File: tb/tb_ieu_issue_ctrl.sv
// Scoreboard bench for ieu_issue_ctrl: each op's expected issue/forwarding
// result and acceptance latency is queued when driven and checked when the
// controller accepts it. Optional IEU_ISSUE_CTRL_PERF_EN counters are checked
// when the macro is defined.
module tb_ieu_issue_ctrl;
  import ieu_pkg::*;

  typedef struct {
    logic       iss;
    logic [1:0] f1;
    logic [1:0] f2;
    int         wt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_iss_mon = 0;
  int   n_flush_mon = 0;
  exp_t exp_q[$];

  ieu_issue_ctrl_if bus ();

`ifdef IEU_ISSUE_CTRL_PERF_EN
  logic [31:0] perf_issued, perf_stalls, perf_flushes;
`endif

  ieu_issue_ctrl #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IEU_ISSUE_CTRL_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stalls (perf_stalls),
    .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  // Count issue cycles since last reset and flush pulses over the whole run
  always @(negedge clk) begin
    if (reset) n_iss_mon <= 0;
    else if (bus.issue_valid) n_iss_mon <= n_iss_mon + 1;
    if (!reset && bus.flush) n_flush_mon <= n_flush_mon + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one op until accepted; ex_ready held low for the first exr cycles
  task automatic send(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic ld, input logic cf, input logic j,
                      input logic eiss, input logic [1:0] ef1, input logic [1:0] ef2,
                      input int ewt, input int exr);
    exp_t e;
    int   w;
    bit   done;
    e = '{eiss, ef1, ef2, ewt};
    exp_q.push_back(e);
    bus.dec_valid = 1'b1;  bus.dec_rd = rd;  bus.dec_rs1 = rs1;  bus.dec_rs2 = rs2;
    bus.dec_use_rs1 = u1;  bus.dec_use_rs2 = u2;  bus.dec_is_load = ld;
    bus.dec_is_cf = cf;    bus.je = j;
    w = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.ex_ready = (c < exr) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bus.dec_ready) begin
        e = exp_q.pop_front();
        check({tag, "/issue"}, 32'(bus.issue_valid), 32'(e.iss));
        if (e.iss) begin
          check({tag, "/fwd1"}, 32'(bus.fwd_sel1), 32'(e.f1));
          check({tag, "/fwd2"}, 32'(bus.fwd_sel2), 32'(e.f2));
        end
        check({tag, "/wait"}, 32'(w), 32'(e.wt));
        done = 1'b1;
      end else begin
        check({tag, "/noissue"}, 32'(bus.issue_valid), 32'd0);
        w++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      check({tag, "/timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    bus.dec_valid = 1'b0;
    bus.je = 1'b0;
    bus.ex_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.dec_valid = 1'b0;  bus.dec_rd = 5'd0;  bus.dec_rs1 = 5'd0;  bus.dec_rs2 = 5'd0;
    bus.dec_use_rs1 = 1'b0;  bus.dec_use_rs2 = 1'b0;  bus.dec_is_load = 1'b0;
    bus.dec_is_cf = 1'b0;  bus.je = 1'b0;  bus.ex_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst/dec_ready", 32'(bus.dec_ready), 32'd1);
    check("rst/issue", 32'(bus.issue_valid), 32'd0);
    check("rst/flush", 32'(bus.flush), 32'd0);
    check("rst/fwd1", 32'(bus.fwd_sel1), 32'(FWD_RF));
    @(posedge clk); #1;

    // Result forwarding: addi x5; add x6,x5,x1
    send("addi_x5", 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    send("add_x6",  5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RES, FWD_RF, 0, 0);
    idle(1);

    // Load-use: lw x7; add x8,x7,x7; add x9,x8,x7
    send("lw_x7",  5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    send("add_x8", 5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_LD, FWD_LD, 2, 0);
    send("add_x9", 5'd9, 5'd8, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RES, FWD_RF, 0, 0);

    // x0 never forwards or stalls
    send("addi_x0", 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    send("rd_x0",   5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    send("lw_x0",   5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, FWD_RES, FWD_RF, 0, 0);
    send("use_x0",  5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);

    // Taken branch: flush pulse, two ops discarded, third issues
    send("beq_tk", 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, FWD_RF, FWD_RES, 0, 0);
    @(negedge clk);
    check("beq_tk/flush", 32'(bus.flush), 32'd1);
    @(posedge clk); #1;
    send("wp0",  5'd3, 5'd2, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FWD_RF, FWD_RF, 0, 0);
    send("wp1",  5'd3, 5'd2, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FWD_RF, FWD_RF, 0, 0);
    send("tgt",  5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    check("flush_pulses1", 32'(n_flush_mon), 32'd1);

    // je ignored on non-cf op; not-taken cf op does not flush
    send("je_noncf", 5'd5, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, FWD_RES, FWD_RF, 0, 0);
    send("after_je", 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RES, FWD_RES, 0, 0);
    send("beq_nt",   5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FWD_RES, FWD_RF, 0, 0);
    send("after_nt", 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    check("flush_pulses2", 32'(n_flush_mon), 32'd1);
    idle(1);

    // Back-pressure for 3 cycles: W held, forwarding intact on resume
    send("addi_x10", 5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    send("add_x11",  5'd11, 5'd10, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RES, FWD_RF, 3, 3);

    // Reset while in FLUSH with one wrong-path op left
    send("beq_rst", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, FWD_RF, FWD_RF, 0, 0);
    send("wp_rst",  5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD_RF, FWD_RF, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rstfl/dec_ready", 32'(bus.dec_ready), 32'd1);
    check("rstfl/flush", 32'(bus.flush), 32'd0);
`ifdef IEU_ISSUE_CTRL_PERF_EN
    check("rstfl/perf_issued", perf_issued, 32'd0);
    check("rstfl/perf_stalls", perf_stalls, 32'd0);
    check("rstfl/perf_flushes", perf_flushes, 32'd0);
`endif
    @(posedge clk); #1;
    send("post_rst", 5'd3, 5'd10, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    check("flush_pulses3", 32'(n_flush_mon), 32'd2);

    // Reset while in LOAD_STALL
    send("lw_x4", 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    bus.dec_valid = 1'b1;  bus.dec_rd = 5'd5;  bus.dec_rs1 = 5'd4;  bus.dec_rs2 = 5'd0;
    bus.dec_use_rs1 = 1'b1;  bus.dec_use_rs2 = 1'b0;  bus.dec_is_load = 1'b0;  bus.dec_is_cf = 1'b0;
    @(negedge clk);
    check("rstls/hazard", 32'(bus.dec_ready), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    send("rstls/op", 5'd5, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);

    // One more load-use stall to exercise the stall counter
    send("lw_x12",  5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_RF, 0, 0);
    send("add_x13", 5'd13, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWD_RF, FWD_LD, 2, 0);
    idle(2);
`ifdef IEU_ISSUE_CTRL_PERF_EN
    check("perf_issued", perf_issued, 32'(n_iss_mon));
    check("perf_stalls", perf_stalls, 32'd1);
    check("perf_flushes", perf_flushes, 32'd0);
`endif
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
